// File: rtl/dft_pkg.sv
// Shared constants, FSM state type and output scaling helper for the
// 128-point inverse DFT synthesiser.
package dft_pkg;

   localparam int unsigned N         = 128;
   localparam int unsigned LOG2N     = 7;
   localparam int unsigned COEF_W    = 32;
   localparam int unsigned BASIS_W   = 16;
   localparam int unsigned ACC_W     = 56;
   localparam int unsigned OUT_SHIFT = 22;
   localparam int unsigned HI_W      = ACC_W - OUT_SHIFT;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUT
   } state_t;

   // Takes acc[ACC_W-1:OUT_SHIFT] (already floor-scaled) and clamps it to Q16.16.
   function automatic logic [COEF_W-1:0] sat_out(input logic [HI_W-1:0] hi);
      logic [HI_W-COEF_W:0] top;
      top = hi[HI_W-1:COEF_W-1];
      if ((top == '0) || (top == '1))
         sat_out = hi[COEF_W-1:0];
      else if (hi[HI_W-1])
         sat_out = {1'b1, {(COEF_W-1){1'b0}}};
      else
         sat_out = {1'b0, {(COEF_W-1){1'b1}}};
   endfunction

endpackage

// File: rtl/idft_if.sv
// Coefficient load, start/status, basis ROM and sample output signals of the IDFT.
interface idft_if;
   import dft_pkg::*;

   logic                 coef_we;
   logic [LOG2N-1:0]     coef_addr;
   logic [COEF_W-1:0]    coef_cos;
   logic [COEF_W-1:0]    coef_sin;
   logic                 start_in;
   logic [LOG2N-1:0]     basis_addr;
   logic [BASIS_W-1:0]   basis_cos;
   logic [BASIS_W-1:0]   basis_sin;
   logic                 time_valid;
   logic [LOG2N-1:0]     time_index_out;
   logic [COEF_W-1:0]    time_data_out;
   logic                 busy;
   logic                 done;

   modport master (
      output coef_we, coef_addr, coef_cos, coef_sin, start_in, basis_cos, basis_sin,
      input  basis_addr, time_valid, time_index_out, time_data_out, busy, done
   );

   modport slave (
      input  coef_we, coef_addr, coef_cos, coef_sin, start_in, basis_cos, basis_sin,
      output basis_addr, time_valid, time_index_out, time_data_out, busy, done
   );

endinterface

// File: rtl/idft_mac.sv
// Two-stage datapath: register a_k*cos and b_k*sin, then sum them into the
// 56-bit accumulator. Exposes the scaled upper bits of the next accumulator value.
module idft_mac
   import dft_pkg::*;
(
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      i_clr,
   input  logic                      i_en,
   input  logic signed [COEF_W-1:0]  i_a,
   input  logic signed [COEF_W-1:0]  i_b,
   input  logic signed [BASIS_W-1:0] i_cos,
   input  logic signed [BASIS_W-1:0] i_sin,
   output logic [HI_W-1:0]           o_acc_hi
);

   localparam int unsigned PROD_W = COEF_W + BASIS_W;
   localparam int unsigned SUM_W  = PROD_W + 1;

   logic signed [PROD_W-1:0] w_a, w_b, w_c, w_s;
   logic signed [PROD_W-1:0] r_pa, r_pb;
   logic                     r_pvld;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;

   assign w_a = {{BASIS_W{i_a[COEF_W-1]}}, i_a};
   assign w_b = {{BASIS_W{i_b[COEF_W-1]}}, i_b};
   assign w_c = {{COEF_W{i_cos[BASIS_W-1]}}, i_cos};
   assign w_s = {{COEF_W{i_sin[BASIS_W-1]}}, i_sin};

   assign w_sum     = {r_pa[PROD_W-1], r_pa} + {r_pb[PROD_W-1], r_pb};
   assign w_acc_nxt = r_pvld ? (r_acc + {{(ACC_W-SUM_W){w_sum[SUM_W-1]}}, w_sum}) : r_acc;
   assign o_acc_hi  = w_acc_nxt[ACC_W-1:OUT_SHIFT];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_pa   <= '0;
         r_pb   <= '0;
         r_pvld <= 1'b0;
         r_acc  <= '0;
      end else begin
         r_pvld <= i_en;
         if (i_en) begin
            r_pa <= w_a * w_c;
            r_pb <= w_b * w_s;
         end
         if (i_clr)
            r_acc <= '0;
         else
            r_acc <= w_acc_nxt;
      end
   end

endmodule

// File: rtl/idft.sv
// 128-point inverse DFT: per sample n, sweeps k=0..127 reading coefficients
// and basis values at phase n*k, accumulates, then emits a saturated Q16.16 sample.
module idft
   import dft_pkg::*;
(
   input  logic  clk,
   input  logic  n_reset,
   idft_if.slave bus
);

   state_t                r_state;
   logic [LOG2N-1:0]      r_n, r_k, r_phase, r_idx;
   logic                  r_drn, r_rd_vld, r_valid, r_busy, r_done;
   logic [COEF_W-1:0]     r_data;
   logic [2*COEF_W-1:0]   r_ram [N];
   logic [2*COEF_W-1:0]   r_rd;
   logic [HI_W-1:0]       w_acc_hi;
   logic                  w_clr;

   // Coefficient RAM is deliberately outside the reset domain so it survives n_reset.
   always_ff @(posedge clk) begin
      if (bus.coef_we && !r_busy)
         r_ram[bus.coef_addr] <= {bus.coef_cos, bus.coef_sin};
      r_rd <= r_ram[r_k];
   end

   assign w_clr = (r_state == IDLE) || (r_state == OUT);

   idft_mac u_mac (
      .clk      (clk),
      .n_reset  (n_reset),
      .i_clr    (w_clr),
      .i_en     (r_rd_vld),
      .i_a      (r_rd[2*COEF_W-1:COEF_W]),
      .i_b      (r_rd[COEF_W-1:0]),
      .i_cos    (bus.basis_cos),
      .i_sin    (bus.basis_sin),
      .o_acc_hi (w_acc_hi)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state  <= IDLE;
         r_n      <= '0;
         r_k      <= '0;
         r_phase  <= '0;
         r_drn    <= 1'b0;
         r_rd_vld <= 1'b0;
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_rd_vld <= (r_state == ISSUE);
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start_in) begin
                  r_state <= ISSUE;
                  r_busy  <= 1'b1;
                  r_n     <= '0;
                  r_k     <= '0;
                  r_phase <= '0;
               end
            end
            ISSUE: begin
               r_k     <= r_k + LOG2N'(1);
               r_phase <= r_phase + r_n;
               if (r_k == '1) begin
                  r_state <= DRAIN;
                  r_drn   <= 1'b0;
                  r_phase <= '0;
               end
            end
            DRAIN: begin
               r_drn <= 1'b1;
               // Final product lands in the accumulator this edge, so scale the next value.
               if (r_drn) begin
                  r_state <= OUT;
                  r_valid <= 1'b1;
                  r_idx   <= r_n;
                  r_data  <= sat_out(w_acc_hi);
               end
            end
            OUT: begin
               if (r_n == '1) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_n     <= '0;
               end else begin
                  r_state <= ISSUE;
                  r_n     <= r_n + LOG2N'(1);
                  r_k     <= '0;
                  r_phase <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.basis_addr     = r_phase;
   assign bus.time_valid     = r_valid;
   assign bus.time_index_out = r_idx;
   assign bus.time_data_out  = r_data;
   assign bus.busy           = r_busy;
   assign bus.done           = r_done;

endmodule

// File: tb/tb_idft.sv
// Directed self-checking bench for idft: stub and true basis ROMs, timing,
// saturation, reset abort and busy-time write/start rejection.
module tb_idft;
   import dft_pkg::*;

   logic clk = 1'b0;
   logic n_reset;
   idft_if bus ();

   idft dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_cnt = 0;
   int          s0 = 0;
   int          rom_mode = 0;
   logic [15:0] stub_cos = '0;
   logic [15:0] stub_sin = '0;
   int          cos_t [128];
   int          sin_t [128];
   int          a_c [128];
   int          b_c [128];
   logic [31:0] exp_data [128];

   always @(posedge clk) edge_cnt = edge_cnt + 1;

   // Registered basis ROM: data follows basis_addr by one cycle.
   always @(posedge clk) begin
      if (rom_mode == 0) begin
         bus.basis_cos <= stub_cos;
         bus.basis_sin <= stub_sin;
      end else begin
         bus.basis_cos <= 16'(cos_t[bus.basis_addr]);
         bus.basis_sin <= 16'(sin_t[bus.basis_addr]);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero_outputs(input string pfx);
      check_eq({pfx, "_basis_addr"}, 64'(bus.basis_addr), 64'd0);
      check_eq({pfx, "_time_valid"}, 64'(bus.time_valid), 64'd0);
      check_eq({pfx, "_time_index"}, 64'(bus.time_index_out), 64'd0);
      check_eq({pfx, "_time_data"}, 64'(bus.time_data_out), 64'd0);
      check_eq({pfx, "_busy"}, 64'(bus.busy), 64'd0);
      check_eq({pfx, "_done"}, 64'(bus.done), 64'd0);
   endtask

   task automatic load_ram();
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         bus.coef_we   = 1'b1;
         bus.coef_addr = 7'(k);
         bus.coef_cos  = 32'(a_c[k]);
         bus.coef_sin  = 32'(b_c[k]);
      end
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic do_reset(input string pfx);
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      check_zero_outputs(pfx);
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
   endtask

   // Start pulse at cycle 0, optionally with a same-cycle coefficient write; returns in cycle 1.
   task automatic start_frame(input bit with_wr, input int wr_k, input int wr_a, input int wr_b);
      @(negedge clk);
      bus.start_in = 1'b1;
      if (with_wr) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = 7'(wr_k);
         bus.coef_cos  = 32'(wr_a);
         bus.coef_sin  = 32'(wr_b);
      end
      s0 = edge_cnt;
      @(negedge clk);
      bus.start_in = 1'b0;
      bus.coef_we  = 1'b0;
      check_eq("busy_rise", 64'(bus.busy), 64'd1);
   endtask

   task automatic watch_frame(input int nsamp, input bit chk_basis, input int inj_cyc);
      int  n;
      bit  fin;
      n   = 0;
      fin = 1'b0;
      for (int i = 0; i < 17000 && !fin; i++) begin
         int c;
         @(negedge clk);
         c = edge_cnt - s0;
         if (inj_cyc != 0 && c == inj_cyc) begin
            bus.start_in  = 1'b1;
            bus.coef_we   = 1'b1;
            bus.coef_addr = 7'd0;
            bus.coef_cos  = 32'h1234_0000;
            bus.coef_sin  = 32'h0;
         end else if (inj_cyc != 0 && c == inj_cyc + 1) begin
            bus.start_in = 1'b0;
            bus.coef_we  = 1'b0;
         end
         if (chk_basis && c >= 394 && c <= 521)
            check_eq($sformatf("basis_n3_c%0d", c), 64'(bus.basis_addr), 64'((3 * (c - 394)) % 128));
         if (bus.time_valid) begin
            check_eq($sformatf("idx_n%0d", n), 64'(bus.time_index_out), 64'(n));
            check_eq($sformatf("vcyc_n%0d", n), 64'(c), 64'(131 * (n + 1)));
            check_eq($sformatf("data_n%0d", n), 64'(bus.time_data_out), 64'(exp_data[n]));
            if (n == 127)
               check_eq("busy_last", 64'(bus.busy), 64'd1);
            n++;
            if (nsamp < 128 && n == nsamp)
               fin = 1'b1;
         end
         if (bus.done) begin
            check_eq("done_cyc", 64'(c), 64'd16769);
            check_eq("busy_fall", 64'(bus.busy), 64'd0);
            check_eq("nsamples", 64'(n), 64'd128);
            check_eq("basis_idle", 64'(bus.basis_addr), 64'd0);
            fin = 1'b1;
         end
      end
      if (!fin)
         check_eq("frame_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      real ph;
      int  v;
      for (int i = 0; i < 128; i++) begin
         ph = 2.0 * 3.14159265358979 * real'(i) / 128.0;
         v = int'($cos(ph) * 32768.0);
         cos_t[i] = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
         v = int'($sin(ph) * 32768.0);
         sin_t[i] = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
      end

      n_reset       = 1'b1;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_cos  = '0;
      bus.coef_sin  = '0;
      bus.start_in  = 1'b0;
      #2 n_reset = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("por");
      n_reset = 1'b1;
      @(negedge clk);
      check_eq("basis_idle0", 64'(bus.basis_addr), 64'd0);

      // Unit coefficients, cos=0.5: every sample 0.5; a_5 arrives with the start pulse.
      rom_mode = 0; stub_cos = 16'h4000; stub_sin = 16'h0000;
      for (int k = 0; k < 128; k++) begin
         a_c[k] = 32'h0001_0000; b_c[k] = 0; exp_data[k] = 32'h0000_8000;
      end
      a_c[5] = 0;
      load_ram();
      start_frame(1'b1, 5, 32'h0001_0000, 0);
      watch_frame(128, 1'b1, 0);

      // True ROM, a_0=128.0 only: cos(0)=0x7FFF gives 2*32767 per sample.
      rom_mode = 1;
      for (int k = 0; k < 128; k++) begin
         a_c[k] = 0; b_c[k] = 0; exp_data[k] = 32'h0000_FFFE;
      end
      a_c[0] = 32'h0080_0000;
      load_ram();
      start_frame(1'b0, 0, 0, 0);
      watch_frame(128, 1'b0, 0);

      // Positive and negative saturation; RAM is reused across the reset between them.
      rom_mode = 0; stub_cos = 16'h7FFF; stub_sin = 16'h7FFF;
      for (int k = 0; k < 128; k++) begin
         a_c[k] = 32'h7FFF_FFFF; b_c[k] = 32'h7FFF_FFFF; exp_data[k] = 32'h7FFF_FFFF;
      end
      load_ram();
      start_frame(1'b0, 0, 0, 0);
      watch_frame(4, 1'b0, 0);
      do_reset("rst_satp");
      stub_cos = 16'h8000; stub_sin = 16'h8000;
      for (int k = 0; k < 128; k++) exp_data[k] = 32'h8000_0000;
      start_frame(1'b0, 0, 0, 0);
      watch_frame(4, 1'b0, 0);
      do_reset("rst_satn");

      // a_1=b_2=128.0 on the true ROM: x[n] = 2*cos_t[n] + 2*sin_t[2n mod 128] exactly.
      rom_mode = 1;
      for (int k = 0; k < 128; k++) begin
         a_c[k] = 0; b_c[k] = 0;
      end
      a_c[1] = 32'h0080_0000;
      b_c[2] = 32'h0080_0000;
      for (int n = 0; n < 128; n++)
         exp_data[n] = 32'(2 * (cos_t[n] + sin_t[(2 * n) % 128]));
      load_ram();
      start_frame(1'b0, 0, 0, 0);
      repeat (499) @(negedge clk);
      n_reset = 1'b0;
      #1;
      check_zero_outputs("rst_c500");
      repeat (3) @(negedge clk);
      check_eq("rst_hold_valid", 64'(bus.time_valid), 64'd0);
      n_reset = 1'b1;
      @(negedge clk);
      check_eq("rel_busy", 64'(bus.busy), 64'd0);

      // Full frame with retained RAM; start/write pulsed at cycle 1000 must be ignored.
      start_frame(1'b0, 0, 0, 0);
      watch_frame(128, 1'b0, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
